// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the four-master bus arbiter.
package bus_arbiter_pkg;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;

  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

  // Active-low request/grant polarity used across the bus.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    BUS_IDLE    = 1'b0,
    BUS_GRANTED = 1'b1
  } bus_state_t;

  // Active-low one-hot grant vector for a given owner index.
  function automatic logic [BUS_MASTER_CH-1:0] grant_vec_n(input logic [BUS_OWNER_W-1:0] idx);
    logic [BUS_MASTER_CH-1:0] vec;
    vec = {BUS_MASTER_CH{DISABLE_}};
    vec[idx] = ENABLE_;
    return vec;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward with
// wrap, optionally skipping one index (the current owner during handover).
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  logic [BUS_OWNER_W-1:0]   last_owner,
  input  logic                     excl_en,
  input  logic [BUS_OWNER_W-1:0]   excl_idx,
  output logic                     found,
  output logic [BUS_OWNER_W-1:0]   sel
);

  logic [BUS_MASTER_CH-1:0] cand;
  logic [BUS_OWNER_W-1:0]   idx;

  generate
    for (genvar gi = 0; gi < BUS_MASTER_CH; gi++) begin : g_mask
      assign cand[gi] = req[gi] & ~(excl_en && (excl_idx == BUS_OWNER_W'(gi)));
    end
  endgenerate

  // Scan from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = BUS_MASTER_CH; k >= 1; k--) begin
      idx = last_owner + BUS_OWNER_W'(k);
      if (cand[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with bounded-hold preemption
// taken only at transfer boundaries (m_rdy=1). All outputs are flops.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m_rdy,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic       grnt_vld,
  output logic [1:0] grnt_owner
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam bit                PREEMPT_EN = (MAX_HOLD != 0);

  bus_state_t               state_reg, state_next;
  logic [BUS_OWNER_W-1:0]   owner_reg, owner_next;
  logic [BUS_OWNER_W-1:0]   last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0]        hold_reg, hold_next;
  logic [BUS_MASTER_CH-1:0] grnt_n_reg, grnt_n_next;
  logic                     grnt_vld_reg, grnt_vld_next;

  logic [BUS_MASTER_CH-1:0] req;
  logic                     owner_req;
  logic                     pick_found;
  logic [BUS_OWNER_W-1:0]   pick_sel;

  // Requests are active-low on the pins; work with active-high internally.
  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req = req[owner_reg];

  // While granted, the owner is never a handover candidate.
  bus_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner_reg),
    .excl_en    (state_reg == BUS_GRANTED),
    .excl_idx   (owner_reg),
    .found      (pick_found),
    .sel        (pick_sel)
  );

  // Next-state and next-output decision: release beats preemption beats hold.
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    hold_next       = hold_reg;
    grnt_n_next     = grnt_n_reg;
    grnt_vld_next   = grnt_vld_reg;

    case (state_reg)
      BUS_IDLE: begin
        if (pick_found) begin
          state_next      = BUS_GRANTED;
          owner_next      = pick_sel;
          last_owner_next = pick_sel;
          hold_next       = '0;
          grnt_n_next     = grant_vec_n(pick_sel);
          grnt_vld_next   = 1'b1;
        end
      end
      BUS_GRANTED: begin
        if (!owner_req) begin
          if (pick_found) begin
            owner_next      = pick_sel;
            last_owner_next = pick_sel;
            hold_next       = '0;
            grnt_n_next     = grant_vec_n(pick_sel);
          end else begin
            state_next    = BUS_IDLE;
            hold_next     = '0;
            grnt_n_next   = {BUS_MASTER_CH{DISABLE_}};
            grnt_vld_next = 1'b0;
          end
        end else if (PREEMPT_EN && (hold_reg >= HOLD_LIMIT) && m_rdy && pick_found) begin
          owner_next      = pick_sel;
          last_owner_next = pick_sel;
          hold_next       = '0;
          grnt_n_next     = grant_vec_n(pick_sel);
        end else if (hold_reg < HOLD_LIMIT) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        state_next    = BUS_IDLE;
        grnt_n_next   = {BUS_MASTER_CH{DISABLE_}};
        grnt_vld_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_reg      <= BUS_IDLE;
      owner_reg      <= BUS_OWNER_MASTER_0;
      last_owner_reg <= BUS_OWNER_MASTER_3;
      hold_reg       <= '0;
      grnt_n_reg     <= {BUS_MASTER_CH{DISABLE_}};
      grnt_vld_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      hold_reg       <= hold_next;
      grnt_n_reg     <= grnt_n_next;
      grnt_vld_reg   <= grnt_vld_next;
    end
  end

  assign m0_grnt_   = grnt_n_reg[0];
  assign m1_grnt_   = grnt_n_reg[1];
  assign m2_grnt_   = grnt_n_reg[2];
  assign m3_grnt_   = grnt_n_reg[3];
  assign grnt_vld   = grnt_vld_reg;
  assign grnt_owner = owner_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=0) share the
// stimulus; a directed vector table, a no-preemption soak and a random phase
// are all checked against an arithmetic round-robin reference model.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_;
  logic [3:0] req_n;
  logic       m_rdy;

  logic [3:0] ga_n, gb_n;
  logic       va, vb;
  logic [1:0] oa, ob;

  int errors = 0;
  int checks = 0;

  int mdl_own[2];
  int mdl_last[2];
  int mdl_hold[2];
  int mdl_max[2] = '{4, 0};

  typedef struct {
    logic       rst_n;
    logic [3:0] req_n;
    logic       rdy;
    logic [3:0] exp_g;
    logic       exp_v;
    logic [1:0] exp_o;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(4), .HOLD_W(5)) dut_a (
    .clk(clk), .reset_(reset_),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m_rdy(m_rdy),
    .m0_grnt_(ga_n[0]), .m1_grnt_(ga_n[1]), .m2_grnt_(ga_n[2]), .m3_grnt_(ga_n[3]),
    .grnt_vld(va), .grnt_owner(oa)
  );

  bus_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) dut_b (
    .clk(clk), .reset_(reset_),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m_rdy(m_rdy),
    .m0_grnt_(gb_n[0]), .m1_grnt_(gb_n[1]), .m2_grnt_(gb_n[2]), .m3_grnt_(gb_n[3]),
    .grnt_vld(vb), .grnt_owner(ob)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // First requester after 'last' in ascending, wrapping order, skipping 'excl'.
  function automatic int rr_next(input int last, input int excl, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (c != excl && req[c]) return c;
    end
    return -1;
  endfunction

  // One clock of the reference arbiter; mdl_own = -1 means no grant.
  task automatic model_step(input int i);
    int cand;
    if (!reset_) begin
      mdl_own[i]  = -1;
      mdl_last[i] = 3;
      mdl_hold[i] = 0;
    end else if (mdl_own[i] < 0) begin
      cand = rr_next(mdl_last[i], -1, ~req_n);
      if (cand >= 0) begin
        mdl_own[i] = cand; mdl_last[i] = cand; mdl_hold[i] = 0;
      end
    end else begin
      cand = rr_next(mdl_last[i], mdl_own[i], ~req_n);
      if (req_n[mdl_own[i]]) begin
        if (cand >= 0) begin
          mdl_own[i] = cand; mdl_last[i] = cand;
        end else begin
          mdl_own[i] = -1;
        end
        mdl_hold[i] = 0;
      end else if (mdl_max[i] != 0 && mdl_hold[i] >= mdl_max[i] && m_rdy && cand >= 0) begin
        mdl_own[i] = cand; mdl_last[i] = cand; mdl_hold[i] = 0;
      end else if (mdl_hold[i] < mdl_max[i]) begin
        mdl_hold[i]++;
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [3:0] g, input logic v, input logic [1:0] o,
                           input string tag);
    logic [3:0] eg;
    eg = (mdl_own[i] < 0) ? 4'hF : ~(4'b0001 << mdl_own[i]);
    check({tag, "_grnt_n"}, int'(g), int'(eg));
    check({tag, "_vld"}, int'(v), (mdl_own[i] >= 0) ? 1 : 0);
    if (mdl_own[i] >= 0) check({tag, "_owner"}, int'(o), mdl_own[i]);
    check({tag, "_onehot"}, ($countones(~g) <= 1) ? 1 : 0, 1);
  endtask

  // Apply inputs just after an edge, advance both models, sample 1 time unit after the next edge.
  task automatic cycle(input logic rst, input logic [3:0] rq, input logic rdy);
    reset_ = rst;
    req_n  = rq;
    m_rdy  = rdy;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_dut(0, ga_n, va, oa, "a");
    check_dut(1, gb_n, vb, ob, "b");
  endtask

  task automatic add(input logic rst, input logic [3:0] rq, input logic rdy,
                     input logic [3:0] g, input logic v, input logic [1:0] o, input int n);
    vec_t e;
    e.rst_n = rst; e.req_n = rq; e.rdy = rdy; e.exp_g = g; e.exp_v = v; e.exp_o = o;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] r;

    // Reset with all masters requesting, then m0 first.
    add(0, 4'b0000, 0, 4'b1111, 0, 0, 3);
    add(1, 4'b0000, 0, 4'b1110, 1, 0, 1);
    add(1, 4'b1111, 0, 4'b1111, 0, 0, 1);
    // Single requester: one-cycle latency, release to idle.
    add(1, 4'b1011, 0, 4'b1011, 1, 2, 2);
    add(1, 4'b1111, 0, 4'b1111, 0, 0, 1);
    // Round-robin handover m0 -> m1 -> m3 -> m0 with no gap cycle.
    add(1, 4'b1110, 0, 4'b1110, 1, 0, 1);
    add(1, 4'b0100, 0, 4'b1110, 1, 0, 1);
    add(1, 4'b0101, 0, 4'b1101, 1, 1, 2);
    add(1, 4'b0111, 0, 4'b0111, 1, 3, 1);
    add(1, 4'b0110, 0, 4'b0111, 1, 3, 1);
    add(1, 4'b1110, 0, 4'b1110, 1, 0, 1);
    add(1, 4'b1111, 0, 4'b1111, 0, 0, 1);
    // Release and preemption conditions together: release path, next requester m2.
    add(1, 4'b1101, 1, 4'b1101, 1, 1, 1);
    add(1, 4'b1001, 0, 4'b1101, 1, 1, 4);
    add(1, 4'b0011, 1, 4'b1011, 1, 2, 1);
    add(1, 4'b1111, 0, 4'b1111, 0, 0, 1);
    // Preemption held off by m_rdy=0 for 8 cycles, taken on the ready cycle.
    add(1, 4'b1101, 0, 4'b1101, 1, 1, 1);
    add(1, 4'b1001, 0, 4'b1101, 1, 1, 8);
    add(1, 4'b1001, 1, 4'b1011, 1, 2, 5);
    // Preempted m1 re-enters the rotation and wins back after m2 hits the limit.
    add(1, 4'b1001, 1, 4'b1101, 1, 1, 1);
    // Owner alone past the limit with m_rdy=1: nobody to hand to, grant kept.
    add(1, 4'b1101, 1, 4'b1101, 1, 1, 6);
    // Reset mid-grant drops the grant; afterwards search restarts at m0.
    add(0, 4'b1101, 1, 4'b1111, 0, 0, 1);
    add(1, 4'b1101, 0, 4'b1101, 1, 1, 1);
    add(1, 4'b1111, 0, 4'b1111, 0, 0, 1);

    reset_ = 1'b0; req_n = 4'hF; m_rdy = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      cycle(tbl[n].rst_n, tbl[n].req_n, tbl[n].rdy);
      check($sformatf("vec%0d_grnt_n", n), int'(ga_n), int'(tbl[n].exp_g));
      check($sformatf("vec%0d_vld", n), int'(va), int'(tbl[n].exp_v));
      if (tbl[n].exp_v || !tbl[n].rst_n)
        check($sformatf("vec%0d_owner", n), int'(oa), int'(tbl[n].exp_o));
      $display("vec %0d: rst_n=%b req_n=%b rdy=%b -> grnt_n=%b vld=%b owner=%0d", n,
               tbl[n].rst_n, tbl[n].req_n, tbl[n].rdy, ga_n, va, oa);
    end

    // Preemption disabled: m3 keeps the bus for 100 cycles while m0 waits.
    cycle(1, 4'b0111, 0);
    check("b_m3_grant", int'(ob), 3);
    for (int k = 0; k < 100; k++) begin
      cycle(1, 4'b0110, 1);
      check("b_no_preempt_owner", int'(ob), 3);
      check("b_no_preempt_grnt_n", int'(gb_n), 4'b0111);
    end
    cycle(1, 4'b1110, 1);
    check("b_after_release_owner", int'(ob), 0);
    $display("soak: MAX_HOLD=0 owner held 100 cycles, then handed to m%0d", ob);

    // Randomized phase with sticky requests and rare resets.
    r = 4'hF;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      cycle(($urandom_range(99) != 0) ? 1'b1 : 1'b0, r, 1'($urandom_range(1)));
      if (k % 100 == 99)
        $display("random %0d: req_n=%b grnt_a=%b grnt_b=%b errors=%0d", k + 1, r, ga_n, gb_n, errors);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
